// File: rtl/usb_in_packetizer_if.sv
// Bundle of the token/handshake decoder, EP0 IN byte stream and byte transmitter signals.
// slave: the packetizer's view; master: the environment that feeds and drains it.
// clk/rst are carried as plain ports alongside this interface.
interface usb_in_packetizer_if;
  // token decoder
  logic       token_vld;
  logic [3:0] token_pid;
  logic [6:0] token_addr;
  logic [3:0] token_ep;
  // handshake decoder
  logic       hs_vld;
  logic [3:0] hs_pid;
  // control handler status
  logic [6:0] dev_addr;
  logic       stall;
  logic       in_seq;
  logic [7:0] in_dat;
  logic       in_rdy;
  logic       in_zlp;
  logic       in_iso;
  logic       in_wait_req;
  logic       in_ack;
  logic       error;
  // byte transmitter
  logic [7:0] tx_dat;
  logic       tx_vld;
  logic       tx_sop;
  logic       tx_eop;
  logic       tx_rdy;

  modport slave (
    input  token_vld, token_pid, token_addr, token_ep,
    input  hs_vld, hs_pid,
    input  dev_addr, stall, in_seq, in_dat, in_rdy, in_zlp, in_iso,
    output in_wait_req, in_ack, error,
    output tx_dat, tx_vld, tx_sop, tx_eop,
    input  tx_rdy
  );

  modport master (
    output token_vld, token_pid, token_addr, token_ep,
    output hs_vld, hs_pid,
    output dev_addr, stall, in_seq, in_dat, in_rdy, in_zlp, in_iso,
    input  in_wait_req, in_ack, error,
    input  tx_dat, tx_vld, tx_sop, tx_eop,
    output tx_rdy
  );
endinterface

// File: rtl/usb_in_packetizer.sv
// Purpose: answers EP0 IN tokens with DATA0/1 + CRC16 (payload pulled from the control handler), NAK or STALL, then waits for the host ACK.
// Latency: PID/handshake byte is presented the cycle after a matching token; each payload byte costs one fetch cycle plus its transmit cycle(s).
// Backpressure: every Tx byte is held stable until tx_rdy; payload bytes are pulled only in FETCH, one per in_wait_req low cycle.
module usb_in_packetizer #(
  parameter int MAX_PACKET  = 64,
  parameter int ACK_TIMEOUT = 1000
) (
  input logic              clk_i,
  input logic              rst_i,
  usb_in_packetizer_if.slave bus
);

  localparam int CW = $clog2(MAX_PACKET + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PACKET);
  localparam logic [TW-1:0] TMO_CNT = TW'(ACK_TIMEOUT);

  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [7:0] BYTE_DATA0 = 8'hC3;
  localparam logic [7:0] BYTE_DATA1 = 8'h4B;
  localparam logic [7:0] BYTE_NAK   = 8'h5A;
  localparam logic [7:0] BYTE_STALL = 8'h1E;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_FETCH,
    S_DATA,
    S_CRC0,
    S_CRC1,
    S_HS,
    S_WAIT_ACK
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    byte_q, byte_d;     // PID, handshake or payload byte on the wire
  logic [15:0]   crc_q, crc_d;       // running CRC16, uncomplemented
  logic [CW-1:0] cnt_q, cnt_d;       // payload bytes sent in this packet
  logic [TW-1:0] timer_q, timer_d;   // cycles spent waiting for the host handshake
  logic          in_ack_q, in_ack_d;
  logic          error_q, error_d;

  logic          token_match;
  logic          tx_fire;
  logic [CW-1:0] cnt_inc;

  // USB CRC16 over one byte, bits taken LSB first (reflected form of 0x8005).
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] dat);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ dat[i]) c = (c >> 1) ^ 16'hA001;
      else               c = c >> 1;
    end
    return c;
  endfunction

  assign token_match = bus.token_vld && (bus.token_pid == PID_IN) &&
                       (bus.token_addr == bus.dev_addr) && (bus.token_ep == 4'd0);
  assign tx_fire     = bus.tx_vld && bus.tx_rdy;
  assign cnt_inc     = cnt_q + CW'(1);

  // Transmit and upstream outputs decode from registered state only, so reset clears them at once.
  always_comb begin
    bus.tx_vld      = 1'b0;
    bus.tx_sop      = 1'b0;
    bus.tx_eop      = 1'b0;
    bus.tx_dat      = 8'h00;
    bus.in_wait_req = 1'b1;
    bus.in_ack      = in_ack_q;
    bus.error       = error_q;
    case (state_q)
      S_PID: begin
        bus.tx_vld = 1'b1;
        bus.tx_sop = 1'b1;
        bus.tx_dat = byte_q;
      end
      S_FETCH: begin
        bus.in_wait_req = ~bus.in_rdy;
      end
      S_DATA: begin
        bus.tx_vld = 1'b1;
        bus.tx_dat = byte_q;
      end
      S_CRC0: begin
        bus.tx_vld = 1'b1;
        bus.tx_dat = ~crc_q[7:0];
      end
      S_CRC1: begin
        bus.tx_vld = 1'b1;
        bus.tx_eop = 1'b1;
        bus.tx_dat = ~crc_q[15:8];
      end
      S_HS: begin
        bus.tx_vld = 1'b1;
        bus.tx_sop = 1'b1;
        bus.tx_eop = 1'b1;
        bus.tx_dat = byte_q;
      end
      default: ;
    endcase
  end

  // Next-state logic: packet sequencing, payload fetch, CRC accumulation and handshake wait.
  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    crc_d    = crc_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    in_ack_d = 1'b0;
    error_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (token_match) begin
          if (bus.stall) begin
            byte_d  = BYTE_STALL;
            state_d = S_HS;
          end else if (!bus.in_rdy && !bus.in_zlp) begin
            byte_d  = BYTE_NAK;
            state_d = S_HS;
          end else begin
            byte_d  = bus.in_seq ? BYTE_DATA1 : BYTE_DATA0;
            state_d = S_PID;
          end
        end
      end
      S_PID: begin
        if (tx_fire) begin
          cnt_d   = '0;
          crc_d   = 16'hFFFF;
          state_d = bus.in_zlp ? S_CRC0 : S_FETCH;
        end
      end
      S_FETCH: begin
        // an empty stream after at least one byte marks the end of a short packet
        if (bus.in_rdy) begin
          byte_d  = bus.in_dat;
          state_d = S_DATA;
        end else if (cnt_q != '0) begin
          state_d = S_CRC0;
        end
      end
      S_DATA: begin
        if (tx_fire) begin
          crc_d   = crc16_byte(crc_q, byte_q);
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == MAX_CNT) ? S_CRC0 : S_FETCH;
        end
      end
      S_CRC0: begin
        if (tx_fire) state_d = S_CRC1;
      end
      S_CRC1: begin
        if (tx_fire) begin
          if (bus.in_iso) begin
            in_ack_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            timer_d = '0;
            state_d = S_WAIT_ACK;
          end
        end
      end
      S_HS: begin
        if (tx_fire) state_d = S_IDLE;
      end
      S_WAIT_ACK: begin
        // any other bus traffic means the host did not take this packet; it will retry
        if (bus.hs_vld && (bus.hs_pid == PID_ACK)) begin
          in_ack_d = 1'b1;
          state_d  = S_IDLE;
        end else if (bus.hs_vld || bus.token_vld || (timer_q == TMO_CNT)) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      byte_q   <= 8'h00;
      crc_q    <= 16'hFFFF;
      cnt_q    <= '0;
      timer_q  <= '0;
      in_ack_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      crc_q    <= crc_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      in_ack_q <= in_ack_d;
      error_q  <= error_d;
    end
  end

endmodule

// File: tb/tb_usb_in_packetizer.sv
// Bench for usb_in_packetizer: directed tokens/handshakes, an upstream byte source,
// and a scoreboard of expected Tx bytes checked by an independent monitor.
module tb_usb_in_packetizer;
  localparam int MAXP = 64;
  localparam int TMO  = 40;

  typedef struct packed {
    logic [7:0] dat;
    logic       sop;
    logic       eop;
  } txb_t;

  logic clk;
  logic rst;
  usb_in_packetizer_if bus();

  usb_in_packetizer #(.MAX_PACKET(MAXP), .ACK_TIMEOUT(TMO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks, failures;
  int cyc;
  int ack_cnt, err_cnt, err_cyc, eop_cyc, tx_cnt, wlow;
  int rdy_mode;
  txb_t exp_q[$];
  logic [7:0] src[$];
  int src_idx;
  logic src_cons;
  logic hold_prev;
  txb_t held;

  initial begin
    checks = 0; failures = 0; cyc = 0;
    ack_cnt = 0; err_cnt = 0; err_cyc = 0; eop_cyc = 0; tx_cnt = 0; wlow = 0;
    rdy_mode = 0; src_idx = 0; hold_prev = 1'b0; held = '0;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic s, input logic e);
    txb_t t;
    t.dat = d; t.sop = s; t.eop = e;
    exp_q.push_back(t);
  endtask

  task automatic src_drive();
    bus.in_rdy = (src_idx < src.size());
    bus.in_dat = (src_idx < src.size()) ? src[src_idx] : 8'h00;
  endtask

  task automatic src_reset();
    src.delete();
    src_idx = 0;
  endtask

  // Reference CRC: non-reflected 0x8005 register fed bit-reversed bytes MSB first, result reversed and complemented.
  task automatic push_data_pkt(input logic seq, input int start, input int n);
    logic [15:0] c, r;
    logic [7:0] b, rb;
    c = 16'hFFFF;
    push(seq ? 8'h4B : 8'hC3, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      b = src[start + i];
      push(b, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) rb[k] = b[7 - k];
      c = c ^ {rb, 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
    end
    for (int k = 0; k < 16; k++) r[k] = c[15 - k];
    r = ~r;
    push(r[7:0], 1'b0, 1'b0);
    push(r[15:8], 1'b0, 1'b1);
  endtask

  task automatic send_token(input logic [6:0] addr, input logic [3:0] ep, input logic [3:0] pid);
    bus.token_addr = addr; bus.token_ep = ep; bus.token_pid = pid; bus.token_vld = 1'b1;
    @(posedge clk); #1;
    bus.token_vld = 1'b0;
  endtask

  task automatic send_hs(input logic [3:0] pid);
    bus.hs_pid = pid; bus.hs_vld = 1'b1;
    @(posedge clk); #1;
    bus.hs_vld = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d bytes never sent, expected 0 left", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Upstream byte source: a low in_wait_req seen mid-cycle means the byte is taken at the next edge.
  initial begin
    forever begin
      @(negedge clk);
      src_cons = !bus.in_wait_req && !rst;
      @(posedge clk); #1;
      if (src_cons && !rst) begin
        src_idx++;
        wlow++;
      end
      src_drive();
    end
  end

  // Transmitter readiness: 0 = always ready, 1 = ready two cycles of three, 2 = stalled.
  initial begin
    bus.tx_rdy = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        1:       bus.tx_rdy = (cyc % 3) != 0;
        2:       bus.tx_rdy = 1'b0;
        default: bus.tx_rdy = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted byte and checks held bytes stay put.
  initial begin
    txb_t e, a;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
        a.dat = bus.tx_dat; a.sop = bus.tx_sop; a.eop = bus.tx_eop;
        if (bus.in_ack) ack_cnt++;
        if (bus.error) begin
          err_cnt++;
          err_cyc = cyc;
        end
        if (hold_prev) begin
          check("tx_hold_vld", int'(bus.tx_vld), 1);
          check("tx_hold_byte", int'(a), int'(held));
        end
        hold_prev = bus.tx_vld && !bus.tx_rdy;
        held = a;
        if (bus.tx_vld && bus.tx_rdy) begin
          tx_cnt++;
          if (bus.tx_eop) eop_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx_unexpected: got byte 0x%0h sop=%0b eop=%0b, expected no byte", a.dat, a.sop, a.eop);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte{dat,sop,eop}", int'(a), int'(e));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int a0, e0, w0, t0;
    rst = 1'b1;
    bus.token_vld = 1'b0; bus.token_pid = 4'h0; bus.token_addr = 7'h0; bus.token_ep = 4'h0;
    bus.hs_vld = 1'b0; bus.hs_pid = 4'h0;
    bus.dev_addr = 7'd5; bus.stall = 1'b0; bus.in_seq = 1'b0;
    bus.in_dat = 8'h00; bus.in_rdy = 1'b0; bus.in_zlp = 1'b0; bus.in_iso = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_in_wait_req", int'(bus.in_wait_req), 1);
    check("rst_in_ack", int'(bus.in_ack), 0);
    check("rst_error", int'(bus.error), 0);
    check("rst_tx_vld", int'(bus.tx_vld), 0);
    check("rst_tx_sop", int'(bus.tx_sop), 0);
    check("rst_tx_eop", int'(bus.tx_eop), 0);
    check("rst_tx_dat", int'(bus.tx_dat), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // STALL answer
    bus.stall = 1'b1;
    push(8'h1E, 1'b1, 1'b1);
    a0 = ack_cnt; e0 = err_cnt;
    send_token(7'd5, 4'd0, 4'b1001);
    wait_drain("stall");
    repeat (3) @(posedge clk); #1;
    check("stall_no_ack", ack_cnt, a0);
    check("stall_no_err", err_cnt, e0);
    bus.stall = 1'b0;

    // NAK when nothing is ready, then tokens for someone else
    src_reset();
    push(8'h5A, 1'b1, 1'b1);
    send_token(7'd5, 4'd0, 4'b1001);
    wait_drain("nak");
    repeat (2) @(posedge clk); #1;
    t0 = tx_cnt;
    send_token(7'd6, 4'd0, 4'b1001);
    send_token(7'd5, 4'd1, 4'b1001);
    send_token(7'd5, 4'd0, 4'b0001);
    repeat (10) @(posedge clk); #1;
    check("foreign_token_no_tx", tx_cnt, t0);

    // zero-length DATA1 acknowledged
    bus.in_zlp = 1'b1; bus.in_seq = 1'b1;
    push(8'h4B, 1'b1, 1'b0); push(8'h00, 1'b0, 1'b0); push(8'h00, 1'b0, 1'b1);
    a0 = ack_cnt; e0 = err_cnt; w0 = wlow;
    send_token(7'd5, 4'd0, 4'b1001);
    wait_drain("zlp");
    send_hs(4'b0010);
    repeat (2) @(posedge clk); #1;
    check("zlp_ack", ack_cnt, a0 + 1);
    check("zlp_no_err", err_cnt, e0);
    check("zlp_no_fetch", wlow, w0);
    bus.in_zlp = 1'b0; bus.in_seq = 1'b0;

    // "123456789" as DATA0 with a hesitant transmitter
    src_reset();
    for (int i = 0; i < 9; i++) src.push_back(8'(8'h31 + i));
    src_drive();
    rdy_mode = 1;
    push(8'hC3, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) push(8'(8'h31 + i), 1'b0, 1'b0);
    push(8'hC8, 1'b0, 1'b0); push(8'hB4, 1'b0, 1'b1);
    a0 = ack_cnt; w0 = wlow;
    send_token(7'd5, 4'd0, 4'b1001);
    wait_drain("check9");
    rdy_mode = 0;
    send_hs(4'b0010);
    repeat (2) @(posedge clk); #1;
    check("check9_consumed", wlow, w0 + 9);
    check("check9_ack", ack_cnt, a0 + 1);

    // 70 bytes offered: 64 go out, 6 wait for the next token
    src_reset();
    for (int i = 0; i < 70; i++) src.push_back(8'(i * 7 + 3));
    src_drive();
    a0 = ack_cnt;
    push_data_pkt(1'b0, 0, MAXP);
    send_token(7'd5, 4'd0, 4'b1001);
    wait_drain("max_pkt");
    send_hs(4'b0010);
    repeat (2) @(posedge clk); #1;
    check("max_pkt_consumed", src_idx, 64);
    check("max_pkt_ack", ack_cnt, a0 + 1);
    repeat (10) @(posedge clk); #1;
    check("max_pkt_left_alone", src_idx, 64);
    bus.in_seq = 1'b1;
    push_data_pkt(1'b1, 64, 6);
    send_token(7'd5, 4'd0, 4'b1001);
    wait_drain("tail_pkt");
    send_hs(4'b0010);
    repeat (2) @(posedge clk); #1;
    check("tail_pkt_consumed", src_idx, 70);
    check("tail_pkt_ack", ack_cnt, a0 + 2);
    bus.in_seq = 1'b0;

    // Handshake timeout: the wait cycle where the timer reaches TMO is the (TMO+1)th,
    // and the registered pulse follows one cycle later.
    src_reset(); src_drive();
    bus.in_zlp = 1'b1;
    push(8'hC3, 1'b1, 1'b0); push(8'h00, 1'b0, 1'b0); push(8'h00, 1'b0, 1'b1);
    a0 = ack_cnt; e0 = err_cnt;
    send_token(7'd5, 4'd0, 4'b1001);
    wait_drain("timeout");
    repeat (TMO + 10) @(posedge clk); #1;
    check("timeout_err", err_cnt, e0 + 1);
    check("timeout_cycles", err_cyc - eop_cyc, TMO + 2);
    check("timeout_no_ack", ack_cnt, a0);

    // NAK from the host gives an immediate error
    push(8'hC3, 1'b1, 1'b0); push(8'h00, 1'b0, 1'b0); push(8'h00, 1'b0, 1'b1);
    e0 = err_cnt;
    send_token(7'd5, 4'd0, 4'b1001);
    wait_drain("host_nak");
    send_hs(4'b1010);
    repeat (2) @(posedge clk); #1;
    check("host_nak_err", err_cnt, e0 + 1);
    check("host_nak_no_ack", ack_cnt, a0);
    bus.in_zlp = 1'b0;

    // Reset while a payload byte is on the wire
    src_reset();
    src.push_back(8'h31); src.push_back(8'h32);
    src_drive();
    push(8'hC3, 1'b1, 1'b0);
    send_token(7'd5, 4'd0, 4'b1001);
    wait_drain("rst_pid");
    rdy_mode = 2;
    repeat (3) @(posedge clk); #1;
    check("pre_rst_tx_vld", int'(bus.tx_vld), 1);
    check("pre_rst_tx_dat", int'(bus.tx_dat), 8'h31);
    rst = 1'b1;
    #1;
    check("mid_rst_tx_vld", int'(bus.tx_vld), 0);
    check("mid_rst_tx_dat", int'(bus.tx_dat), 0);
    check("mid_rst_tx_sop", int'(bus.tx_sop), 0);
    check("mid_rst_wait_req", int'(bus.in_wait_req), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_mode = 0;
    src_reset(); src_drive();
    repeat (2) @(posedge clk); #1;

    // Isochronous zero-length packet: acknowledged without a handshake
    bus.in_zlp = 1'b1; bus.in_iso = 1'b1;
    push(8'hC3, 1'b1, 1'b0); push(8'h00, 1'b0, 1'b0); push(8'h00, 1'b0, 1'b1);
    a0 = ack_cnt; e0 = err_cnt;
    send_token(7'd5, 4'd0, 4'b1001);
    wait_drain("iso");
    repeat (3) @(posedge clk); #1;
    check("iso_ack", ack_cnt, a0 + 1);
    check("iso_no_err", err_cnt, e0);
    bus.in_zlp = 1'b0; bus.in_iso = 1'b0;

    repeat (3) @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
